mem_master_port: RTL and testbench
==================================

// Module: mem_master_port
// PURPOSE
//  Initiator side of the data-memory port: turns single load/store requests from the CPU datapath into
//  address/writeData/we cycles on one port of the dual-port RAM/IO map, then returns the read data.
//  Handles the memory's registered read latency and blocks writes to the code region (addr[MSB:MSB-1]==00).
//  Sits between the CPU and port A of the RAM and IO blocks; one transaction outstanding at a time.
// PARAMETERS
//  DATA_SIZE     16  data word width
//  ADDRESS_SIZE  12  word address width; top two bits select region (00 code, 01/10 RAM, 11 IO)
//  LATENCY       1   memory read latency in clk cycles (>=1); edge where mem_address sampled -> mem_readData valid
// PORTS
//  clk            in   1             system clock, all logic on posedge
//  reset          in   1             synchronous, active-high reset
//  req_valid      in   1             CPU request present
//  req_ready      out  1             port idle, request accepted when req_valid & req_ready at posedge
//  req_we         in   1             1 = store, 0 = load
//  req_addr       in   ADDRESS_SIZE  word address
//  req_wdata      in   DATA_SIZE     store data
//  resp_valid     out  1             one-cycle pulse: transaction complete
//  resp_rdata     out  DATA_SIZE     load data (store: memory echo of write data; fault: 0)
//  resp_fault     out  1             valid with resp_valid: store to code region was suppressed
//  mem_address    out  ADDRESS_SIZE  to memory port address
//  mem_writeData  out  DATA_SIZE     to memory port write data
//  mem_we         out  1             to memory port write enable
//  mem_readData   in   DATA_SIZE     from memory port registered output
// BEHAVIOUR
//  Reset (sync, high): state IDLE; mem_address=0, mem_writeData=0, mem_we=0, resp_valid=0, resp_rdata=0,
//   resp_fault=0, wait counter=0. req_ready=0 while reset is high. Reset mid-transaction aborts it:
//   mem_we is 0 from the next edge, no resp_valid is ever produced for the aborted request.
//  req_ready = (state==IDLE) & ~reset (combinational). All other outputs registered.
//  FSM: IDLE -> ISSUE on accept; ISSUE -> WAIT; WAIT stays LATENCY cycles (counter LATENCY-1 down to 0)
//   -> RESP; RESP -> IDLE. Acceptance cycle T: req_* latched into mem_* at edge ending T.
//  ISSUE (cycle T+1): mem_address/mem_writeData valid; mem_we=req_we unless fault. mem_we high exactly one cycle.
//  Fault = req_we & (req_addr[ADDRESS_SIZE-1:ADDRESS_SIZE-2]==2'b00); decided at accept; mem_we stays 0.
//  WAIT (T+2..T+1+LATENCY): mem_address held, mem_we=0. At edge ending last WAIT cycle capture
//   mem_readData -> resp_rdata (forced 0 on fault) and resp_fault.
//  RESP (T+2+LATENCY): resp_valid=1 for exactly one cycle; resp_rdata/resp_fault hold until next capture.
//  Latency accept->resp_valid = 2+LATENCY cycles (3 at default). Throughput: one request per 3+LATENCY cycles
//   (new accept earliest in cycle after RESP; req_ready low in ISSUE/WAIT/RESP).
//  req_valid while not ready is ignored (CPU holds it); req_* sampled only at accept edge.
//  IO region (11) and RAM regions: identical timing; the block does not decode IO sub-addresses.
//  Address/data pass through unmodified; no wrap or arithmetic on address.
// TESTING
//  1 Reset held 2 cycles mid-WAIT of a load -> all outputs 0, no resp_valid, req_ready=1 1st cycle after reset.
//  2 Store 16'hBEEF to 12'h400 (RAM) -> mem_we=1 only in T+1 with addr 400; resp_valid T+3, rdata BEEF, fault 0.
//  3 Load 12'h400 after test 2 -> mem_we stays 0; resp_valid T+3, resp_rdata=16'hBEEF.
//  4 Store 16'h1234 to 12'h010 (code) -> mem_we never 1; resp_fault=1, resp_rdata=0; later load 010 unchanged.
//  5 Load 12'hFFE (switches=10'h2A5) -> resp_rdata=16'h02A5 at T+3; req_valid held high across ISSUE/WAIT/RESP
//    gives no extra accept; next accept in cycle after RESP.
//  6 LATENCY=3 build: load -> resp_valid at T+5, mem_address held through 3 WAIT cycles.

Source files
------------

// File: rtl/mem_master_port.sv
// Data-memory initiator port: one load/store in flight, registered memory
// read latency, and stores to the code region suppressed and flagged.
module mem_master_port #(
  parameter int DATA_SIZE    = 16,
  parameter int ADDRESS_SIZE = 12,
  parameter int LATENCY      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [DATA_SIZE-1:0]    resp_rdata,
  output logic                    resp_fault,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [DATA_SIZE-1:0]    mem_writeData,
  output logic                    mem_we,
  input  logic [DATA_SIZE-1:0]    mem_readData
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          fault_q;
  logic          accept;
  logic          fault;
  logic          last_wait;

  assign req_ready = (state == IDLE) & ~reset;
  assign accept    = req_valid & req_ready;
  assign fault     = req_we &
    (req_addr[ADDRESS_SIZE-1:ADDRESS_SIZE-2] == 2'b00);
  assign last_wait = (state == WAIT) && (cnt == '0);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // registered memory-side drive, wait counter and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_we        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_fault    <= 1'b0;
      fault_q       <= 1'b0;
      cnt           <= '0;
    end else begin
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      if (accept) begin
        mem_address   <= req_addr;
        mem_writeData <= req_wdata;
        mem_we        <= req_we & ~fault;
        fault_q       <= fault;
        cnt           <= CW'(LATENCY - 1);
      end
      if (state == WAIT && !last_wait) begin
        cnt <= cnt - 1'b1;
      end
      if (last_wait) begin
        resp_rdata <= fault_q ? '0 : mem_readData;
        resp_fault <= fault_q;
        resp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_master_port.sv
// Directed bench for mem_master_port: a LATENCY=1 instance on a RAM/IO
// model and a LATENCY=3 instance, checked through a response scoreboard.
module tb_mem_master_port;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_valid, a_ready, a_we;
  logic [11:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_rv, a_rf;
  logic [15:0] a_rd;
  logic [11:0] a_maddr;
  logic [15:0] a_mwd, a_mrd;
  logic        a_mwe;

  logic        b_valid, b_ready, b_we;
  logic [11:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_rv, b_rf;
  logic [15:0] b_rd;
  logic [11:0] b_maddr;
  logic [15:0] b_mwd, b_mrd;
  logic        b_mwe;

  logic [9:0]  switches;
  logic [15:0] ram_a [0:4095];
  logic [15:0] ram_b [0:4095];
  logic [15:0] b_p1, b_p2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int we_cnt = 0;
  int we_cyc = -1;
  int acc_cnt = 0;
  int rv_cnt = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  mem_master_port #(.DATA_SIZE(16), .ADDRESS_SIZE(12), .LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rd), .resp_fault(a_rf),
    .mem_address(a_maddr), .mem_writeData(a_mwd), .mem_we(a_mwe),
    .mem_readData(a_mrd)
  );

  mem_master_port #(.DATA_SIZE(16), .ADDRESS_SIZE(12), .LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rd), .resp_fault(b_rf),
    .mem_address(b_maddr), .mem_writeData(b_mwd), .mem_we(b_mwe),
    .mem_readData(b_mrd)
  );

  // memory A: write-first RAM, switches mapped at 12'hFFE, 1-cycle read
  always @(posedge clk) begin
    if (a_mwe) ram_a[a_maddr] <= a_mwd;
    if (a_mwe)                 a_mrd <= a_mwd;
    else if (a_maddr == 12'hFFE) a_mrd <= {6'b0, switches};
    else                       a_mrd <= ram_a[a_maddr];
  end

  // memory B: same map, 3-cycle read pipeline
  always @(posedge clk) begin
    if (b_mwe) ram_b[b_maddr] <= b_mwd;
    b_p1  <= b_mwe ? b_mwd : ram_b[b_maddr];
    b_p2  <= b_p1;
    b_mrd <= b_p2;
  end

  // cycle index and event counters for port A
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_mwe) begin
      we_cnt <= we_cnt + 1;
      we_cyc <= cyc;
    end
    if (a_valid && a_ready) acc_cnt <= acc_cnt + 1;
    if (a_rv) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] rd,
                         input logic rf);
    logic [16:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, 64'(rd), 64'(e[15:0]));
      chk({tag, "_fault"}, 64'(rf), 64'(e[16]));
    end
  endtask

  task automatic wait_ready_a(input string tag);
    int n = 0;
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 64'(a_ready), 64'd1);
  endtask

  task automatic wait_resp_a(input string tag, input int t);
    int n = 0;
    while (!a_rv && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp_cyc"}, 64'(cyc), 64'(t + 3));
    pop_chk(tag, a_rd, a_rf);
  endtask

  task automatic req_a(input string tag, input logic we,
                       input logic [11:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_f);
    int t;
    int w0;
    logic wr;
    wr = we && !exp_f;
    @(negedge clk);
    a_valid = 1'b1;
    a_we    = we;
    a_addr  = addr;
    a_wdata = wd;
    wait_ready_a(tag);
    t  = cyc;
    w0 = we_cnt;
    sb.push_back({exp_f, exp_rd});
    @(negedge clk);
    a_valid = 1'b0;
    chk({tag, "_maddr"}, 64'(a_maddr), 64'(addr));
    chk({tag, "_mwe"}, 64'(a_mwe), 64'(wr));
    wait_resp_a(tag, t);
    chk({tag, "_we_cnt"}, 64'(we_cnt - w0), wr ? 64'd1 : 64'd0);
    if (wr) chk({tag, "_we_cyc"}, 64'(we_cyc), 64'(t + 1));
  endtask

  initial begin
    int t;
    int t2;
    int a0;
    int r0;
    for (int i = 0; i < 4096; i++) begin
      ram_a[i] = 16'h0000;
      ram_b[i] = 16'h0000;
    end
    ram_a[12'h010] = 16'h5A5A;
    ram_a[12'h400] = 16'h1111;
    ram_b[12'h7F0] = 16'hC0DE;
    switches = 10'h2A5;
    reset   = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    // power-on reset
    @(negedge clk);
    @(negedge clk);
    chk("por_outs", 64'({a_maddr, a_mwd, a_mwe, a_rv, a_rd, a_rf}), 64'd0);
    chk("por_ready", 64'(a_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("por_ready_rel", 64'(a_ready), 64'd1);

    // reset held 2 cycles in WAIT of a load aborts it
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 12'h400;
    wait_ready_a("rst");
    t  = cyc;
    r0 = rv_cnt;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_outs1", 64'({a_maddr, a_mwd, a_mwe, a_rv, a_rd, a_rf}), 64'd0);
    chk("rst_ready1", 64'(a_ready), 64'd0);
    @(negedge clk);
    chk("rst_outs2", 64'({a_maddr, a_mwd, a_mwe, a_rv, a_rd, a_rf}), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", 64'(a_ready), 64'd1);
    chk("rst_cyc", 64'(cyc), 64'(t + 4));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_resp", 64'(rv_cnt), 64'(r0));

    // store / load to RAM, faulting store to code, reload code word
    req_a("st_ram", 1'b1, 12'h400, 16'hBEEF, 16'hBEEF, 1'b0);
    req_a("ld_ram", 1'b0, 12'h400, 16'h0000, 16'hBEEF, 1'b0);
    req_a("st_code", 1'b1, 12'h010, 16'h1234, 16'h0000, 1'b1);
    req_a("ld_code", 1'b0, 12'h010, 16'h0000, 16'h5A5A, 1'b0);
    req_a("st_ram2", 1'b1, 12'h800, 16'h00FF, 16'h00FF, 1'b0);
    req_a("ld_ram2", 1'b0, 12'h800, 16'h0000, 16'h00FF, 1'b0);

    // IO load with req_valid held high through the whole transaction
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 12'hFFE;
    wait_ready_a("io");
    t  = cyc;
    a0 = acc_cnt;
    sb.push_back({1'b0, 16'h02A5});
    @(negedge clk);
    chk("io_busy1", 64'(a_ready), 64'd0);
    @(negedge clk);
    chk("io_busy2", 64'(a_ready), 64'd0);
    @(negedge clk);
    chk("io_busy3", 64'(a_ready), 64'd0);
    chk("io_resp_cyc", 64'(a_rv), 64'd1);
    pop_chk("io", a_rd, a_rf);
    @(negedge clk);
    chk("io_reaccept_cyc", 64'(cyc), 64'(t + 4));
    chk("io_ready_again", 64'(a_ready), 64'd1);
    chk("io_acc_once", 64'(acc_cnt), 64'(a0 + 1));
    t2 = cyc;
    switches = 10'h155;
    sb.push_back({1'b0, 16'h0155});
    @(negedge clk);
    a_valid = 1'b0;
    wait_resp_a("io2", t2);

    // LATENCY=3 instance: 5-cycle response, address held through WAIT
    @(negedge clk);
    b_valid = 1'b1; b_we = 1'b0; b_addr = 12'h7F0;
    chk("l3_ready", 64'(b_ready), 64'd1);
    t = cyc;
    sb.push_back({1'b0, 16'hC0DE});
    @(negedge clk);
    b_valid = 1'b0;
    chk("l3_issue", 64'({b_maddr, b_mwe}), 64'({12'h7F0, 1'b0}));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("l3_wait", 64'({b_maddr, b_mwe, b_rv, b_ready}),
          64'({12'h7F0, 3'b000}));
    end
    @(negedge clk);
    chk("l3_resp_cyc", 64'(cyc), 64'(t + 5));
    chk("l3_resp_valid", 64'(b_rv), 64'd1);
    pop_chk("l3", b_rd, b_rf);
    @(negedge clk);
    chk("l3_pulse_end", 64'({b_rv, b_ready}), 64'(2'b01));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit");
  end

endmodule
